// File: rtl/interval_timer.sv
// Sequencing controller around an N-bit increment-by-one counter: start/stop/restart,
// terminal compare against a latched period, one-cycle TICK. All outputs registered.
// Latency: START seen at edge k gives BUSY=1, O=0 after edge k; TICK follows edge k+P+1.
module interval_timer #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         STOP,
  input  logic [N-1:0] PERIOD,
  input  logic         MODE,
  output logic [N-1:0] O,
  output logic         TICK,
  output logic         BUSY,
  output logic         DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] per_q, per_d;
  logic         mode_q, mode_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         at_term;

  // Terminal compare uses the period latched at the last START, never the live input.
  assign at_term = (count_q == per_q);

  // Next-state logic; priority is STOP, then START, then terminal event, then increment.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    per_d   = per_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (START) begin
          per_d   = PERIOD;
          mode_d  = MODE;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (STOP) begin
          state_d = S_IDLE;
        end else if (START) begin
          // Restart still reports a terminal count that coincides with it.
          per_d   = PERIOD;
          mode_d  = MODE;
          count_d = '0;
          tick_d  = at_term;
        end else if (at_term) begin
          tick_d = 1'b1;
          if (mode_q) begin
            count_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          // Wrap cannot occur unnoticed: the compare fires at P before any overflow.
          count_d = count_q + N'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      count_q <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O    = count_q;
  assign TICK = tick_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
